// File: rtl/cp0_unit.sv
// ============================================================================
// Module   : cp0_unit
// Purpose  : Coprocessor-0 exception/interrupt controller at the M stage.
//            Decides when to trap, captures EPC/Cause/SR, serves mfc0/mtc0
//            for SR(12), Cause(13), EPC(14).
// Options  : CP0_PRID_EN - when defined, register 15 reads PRID_VALUE.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module cp0_unit #(
    parameter logic [31:0] HANDLER_PC = 32'h0000_4180,
    parameter logic [31:0] PRID_VALUE = 32'h2024_0707
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        en,
    input  logic [4:0]  cp0Addr,
    input  logic [31:0] cp0In,
    output logic [31:0] cp0Out,
    input  logic [31:0] vpc,
    input  logic        bdIn,
    input  logic [4:0]  excCodeIn,
    input  logic [5:0]  hwInt,
    input  logic        excClr,
    output logic        req,
    output logic [31:0] handlerPc,
    output logic [31:0] epcOut
);

    localparam logic [4:0] c_ADDR_SR    = 5'd12;
    localparam logic [4:0] c_ADDR_CAUSE = 5'd13;
    localparam logic [4:0] c_ADDR_EPC   = 5'd14;
    localparam logic [4:0] c_ADDR_PRID  = 5'd15;

    // Architectural state
    logic [5:0]  sr_im_q,   sr_im_d;
    logic        sr_exl_q,  sr_exl_d;
    logic        sr_ie_q,   sr_ie_d;
    logic        cause_bd_q, cause_bd_d;
    logic [5:0]  cause_ip_q, cause_ip_d;
    logic [4:0]  cause_exc_q, cause_exc_d;
    logic [31:0] epc_q,     epc_d;

    logic        w_int_req;
    logic        w_exc_req;
    logic        w_req;
    logic        w_wr_sr;
    logic        w_wr_epc;

    // EXL masks everything; interrupts additionally need IE and a matching IM bit.
    // Reset suppresses the trap so nothing is recorded on a reset edge.
    always_comb begin
        w_int_req = sr_ie_q & ~sr_exl_q & (|(sr_im_q & hwInt));
        w_exc_req = ~sr_exl_q & (excCodeIn != 5'd0);
        w_req     = (w_int_req | w_exc_req) & ~reset;
        w_wr_sr   = en & ~w_req & (cp0Addr == c_ADDR_SR);
        w_wr_epc  = en & ~w_req & (cp0Addr == c_ADDR_EPC);
    end

    assign req       = w_req;
    assign handlerPc = HANDLER_PC;
    assign epcOut    = epc_q;

    // Next-state selection: trap first, then mtc0, then eret clearing EXL.
    always_comb begin
        sr_im_d     = sr_im_q;
        sr_exl_d    = sr_exl_q;
        sr_ie_d     = sr_ie_q;
        cause_bd_d  = cause_bd_q;
        cause_ip_d  = hwInt;
        cause_exc_d = cause_exc_q;
        epc_d       = epc_q;

        if (w_req) begin
            sr_exl_d    = 1'b1;
            cause_exc_d = w_int_req ? 5'd0 : excCodeIn;
            cause_bd_d  = bdIn;
            epc_d       = bdIn ? (vpc - 32'd4) : vpc;
        end else begin
            // mtc0 to SR overrides an eret in the same cycle
            if (w_wr_sr) begin
                sr_im_d  = cp0In[15:10];
                sr_exl_d = cp0In[1];
                sr_ie_d  = cp0In[0];
            end else if (excClr) begin
                sr_exl_d = 1'b0;
            end
            if (w_wr_epc) begin
                epc_d = cp0In;
            end
        end
    end

    // State registers with synchronous reset to all-zero.
    always_ff @(posedge clk) begin
        if (reset) begin
            sr_im_q     <= 6'd0;
            sr_exl_q    <= 1'b0;
            sr_ie_q     <= 1'b0;
            cause_bd_q  <= 1'b0;
            cause_ip_q  <= 6'd0;
            cause_exc_q <= 5'd0;
            epc_q       <= 32'd0;
        end else begin
            sr_im_q     <= sr_im_d;
            sr_exl_q    <= sr_exl_d;
            sr_ie_q     <= sr_ie_d;
            cause_bd_q  <= cause_bd_d;
            cause_ip_q  <= cause_ip_d;
            cause_exc_q <= cause_exc_d;
            epc_q       <= epc_d;
        end
    end

    // mfc0 read mux over the pre-edge register values.
    always_comb begin
        cp0Out = 32'd0;
        case (cp0Addr)
            c_ADDR_SR:    cp0Out = {16'd0, sr_im_q, 8'd0, sr_exl_q, sr_ie_q};
            c_ADDR_CAUSE: cp0Out = {cause_bd_q, 15'd0, cause_ip_q, 3'd0, cause_exc_q, 2'd0};
            c_ADDR_EPC:   cp0Out = epc_q;
`ifdef CP0_PRID_EN
            c_ADDR_PRID:  cp0Out = PRID_VALUE;
`else
            // PRId disabled: the parameter is masked off so 15 reads as zero
            c_ADDR_PRID:  cp0Out = PRID_VALUE & 32'd0;
`endif
            default:      cp0Out = 32'd0;
        endcase
    end

endmodule

`default_nettype wire
